axi_lite_master: RTL
====================

Name: axi_lite_master

Overview:
- AXI4-Lite initiator. Converts a simple single-beat command/response interface into AXI4-Lite AW/W/B or AR/R transactions.
- Lets PL-side control logic (DMA setup, dataplane config) program AXI-Lite register slaves such as axi_lite_slave.
- One outstanding transaction at a time; read and write share one FSM.

Parameters:
- ADDR_W, 32, address width of cmd_addr/AWADDR/ARADDR
- DATA_W, 32, data width; STRB width = DATA_W/8

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- cmd_wstrb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_write  out  1  echoes cmd_write of the completed transaction
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP
- AWADDR out ADDR_W; AWPROT out 3; AWVALID out 1; AWREADY in 1
- WDATA out DATA_W; WSTRB out DATA_W/8; WVALID out 1; WREADY in 1
- BVALID in 1; BRESP in 2; BREADY out 1
- ARADDR out ADDR_W; ARPROT out 3; ARVALID out 1; ARREADY in 1
- RVALID in 1; RDATA in DATA_W; RRESP in 2; RREADY out 1

Behaviour:
- All outputs registered.
- Reset values:
  - state IDLE, cmd_ready 0.
  - AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid all 0.
  - Address, data, strobe and rsp_* outputs 0.
  - AWPROT/ARPROT are the constant 3'b000.
- cmd_ready rises the first clk after reset release. It is 1 only in IDLE and drops the cycle after acceptance.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - On cmd_valid&&cmd_ready, capture cmd_*.
  - Write: go to WR_REQ and drive AWVALID=WVALID=1 the next cycle, with AWADDR/WDATA/WSTRB from the captured command.
  - Read: go to RD_REQ with ARVALID=1 next cycle.
- WR_REQ:
  - AW and W are tracked independently via aw_done/w_done flags.
  - Each VALID clears the cycle after its own handshake. The slave may accept them in the same cycle or in either order.
  - When both are done, go to WR_RESP with BREADY=1 the next cycle.
- WR_RESP:
  - On BVALID&&BREADY, capture BRESP to rsp_resp, set rsp_write=1 and rsp_rdata=0.
  - BREADY clears; go to RSP with rsp_valid=1 the next cycle.
- RD_REQ: on ARVALID&&ARREADY, ARVALID clears and the FSM goes to RD_RESP with RREADY=1 the next cycle.
- RD_RESP: on RVALID&&RREADY, capture RDATA/RRESP, set rsp_write=0, RREADY clears; go to RSP.
- RSP:
  - rsp_valid and rsp_* stay stable until rsp_ready.
  - Then rsp_valid clears and the FSM returns to IDLE, with cmd_ready=1 the following cycle.
- AXI rules:
  - No VALID depends combinationally on any READY.
  - Once asserted, VALID and its payload stay stable until handshake.
  - BREADY/RREADY are asserted only in their response states.
- Ignored inputs:
  - BVALID arriving before both AW and W are done is ignored: BREADY stays 0 until then.
  - Spurious RVALID/BVALID outside their response states are ignored.
- Latency with an always-ready slave and rsp_ready=1:
  - Accept at cycle 0, AW/W/AR handshake at cycle 1, B/R handshake at cycle 2, rsp_valid at cycle 3.
  - Next cmd_ready at cycle 5.
- Non-OKAY responses (SLVERR/DECERR) pass through unchanged; no retry.
- Reset mid-transaction: all VALID/READY outputs drop asynchronously, the FSM returns to IDLE and the in-flight command is discarded.

Decomposition:
- Package axi_lite_pkg holds:
  - resp_t enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11
  - constant AXI_PROT_DEFAULT = 3'b000
  - master state enum
  - Shared with axi_lite_slave.
- No sub-module. Single FSM module of about 200 lines.

Test Plan:
- Write 0x0000_0010 / 0xDEADBEEF / strb 0xF, slave always ready, BRESP=OKAY -> AW and W handshake at cycle 1, rsp_valid at cycle 3, rsp_write=1, rsp_resp=00.
- Write with WREADY delayed 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held with WDATA stable, BREADY asserted only after the W handshake.
- Read 0x0000_0004, ARREADY delayed 2 cycles, RDATA=0x12345678, RRESP=OKAY -> ARADDR stable while ARVALID is held, rsp_rdata=0x12345678, rsp_write=0.
- Read returning RRESP=DECERR with rsp_ready held low 4 cycles -> rsp_resp=11 stays stable and cmd_ready stays 0 until rsp_ready; back-to-back commands are then accepted.
- Assert rst_n low while WR_REQ is waiting on WREADY -> AWVALID/WVALID/BREADY go 0 immediately; after release cmd_ready=1 on the first cycle and the next command completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default protection value and
// the master FSM state encoding.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } mst_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns single-beat command/response requests into
// AW/W/B or AR/R transactions, one outstanding at a time, all outputs registered.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_W-1:0]     AWADDR,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,

    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,

    input  logic                  BVALID,
    input  logic [1:0]            BRESP,
    output logic                  BREADY,

    output logic [ADDR_W-1:0]     ARADDR,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,

    input  logic                  RVALID,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    output logic                  RREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;

    mst_state_e          state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic                bready_q, bready_d;
    logic                rready_q, rready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    resp_t               rsp_resp_q, rsp_resp_d;

    logic                aw_hs, w_hs, aw_all, w_all;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign aw_hs  = awvalid_q && AWREADY;
    assign w_hs   = wvalid_q && WREADY;
    assign aw_all = aw_done_q || aw_hs;
    assign w_all  = w_done_q || w_hs;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            IDLE: begin
                // cmd_ready is registered, so it appears one cycle after entering IDLE
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_all && w_all) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = resp_t'(BRESP);
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = resp_t'(RRESP);
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWADDR    = awaddr_q;
    assign AWPROT    = AXI_PROT_DEFAULT;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARPROT    = AXI_PROT_DEFAULT;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule
